rv32i_multicycle_control: RTL and testbench
===========================================

// Module: rv32i_multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
//  Consumes the instruction decoder's class flags, drives the instr/data bus handshakes and the IR/ALU/RF/PC write strobes.
//  Detects illegal instructions and bus timeouts, then halts. Counts retired instructions.
// PARAMETERS
//  BUS_TIMEOUT  16  max wait cycles for ibus_ack/dbus_ack before error halt (>=2)
//  CNT_W        32  width of instret counter
// PORTS
//  clk            in   1      core clock; all state changes on rising edge
//  reset          in   1      synchronous, active-high reset
//  run            in   1      start/continue execution; sampled in IDLE and at WB exit
//  ibus_req       out  1      instruction fetch request at PC
//  ibus_ack       in   1      instr valid this cycle
//  ir_w           out  1      1-cycle IR load strobe
//  dec_illegal    in   1      decoder op_code==0 (unrecognised)
//  dec_alu_sel    in   1      instruction uses the ALU
//  dec_reg_w      in   1      instruction writes rd
//  dec_data_r     in   1      load
//  dec_data_w     in   1      store
//  dec_branch     in   1      conditional branch
//  dec_jal        in   1      JAL
//  dec_jalr       in   1      JALR
//  branch_taken   in   1      comparator result, valid in EXEC
//  alu_en         out  1      ALU operand/result register enable
//  dbus_req       out  1      data bus request
//  dbus_we        out  1      1=store, 0=load; valid while dbus_req
//  dbus_ack       in   1      data transfer complete
//  rf_we          out  1      register-file write strobe
//  pc_w           out  1      PC update strobe
//  pc_src         out  2      00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//  halted         out  1      sticky halt
//  bus_err        out  1      sticky: halt caused by bus timeout
//  state          out  3      current state code (debug)
//  instret        out  CNT_W  retired-instruction count, wraps
// BEHAVIOUR
//  Reset: state=IDLE; every strobe/req, halted, bus_err, instret, wait counter =0.
//  Reset mid-operation drops ibus_req/dbus_req on the same edge; no RF/PC write.
//  IDLE: run=1 -> FETCH, else stay.
//  FETCH: ibus_req=1 until ibus_ack. On ack: ir_w=1 for that cycle -> DECODE.
//  DECODE (1 cycle): dec_illegal -> HALT (halted=1, bus_err=0), else -> EXEC.
//  EXEC (1 cycle): alu_en=dec_alu_sel. Next: data_r|data_w -> MEM, else -> WB.
//  MEM: dbus_req=1, dbus_we=dec_data_w, held until dbus_ack -> WB.
//  WB (1 cycle): pc_w=1; instret++.
//   rf_we=dec_reg_w & ~dec_data_w & ~dec_branch.
//   pc_src=10 if dec_jalr; 01 if dec_jal | (dec_branch & branch_taken); else 00.
//   Next: run ? FETCH : IDLE.
//  Latency with immediate acks: ALU/branch/jump 4 cycles, load/store 5; each wait cycle adds 1.
//  Wait counter: cleared on FETCH/MEM entry, +1 per cycle without ack.
//   Count reaches BUS_TIMEOUT-1 with no ack -> HALT, bus_err=1, req deasserted.
//   Ack in the same cycle as the limit wins (no error).
//  HALT: all strobes/reqs 0; ignores run; exits only on reset.
//  instret wraps 2^CNT_W-1 -> 0 silently.
//  Strobes are Moore outputs of state, except rf_we/pc_src (state + dec flags) and ir_w (FETCH & ibus_ack).
// STRUCTURE
//  rv32i_ctrl_defs.vh: state codes IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=7; PC_SRC_* codes.
//  Sub-module bus_wait_timer (clear, count_en, expired) for FETCH/MEM timeout; one instance, shared.
//  Decoder flags are combinational from IR; this block holds no instruction copy.
// TESTING
//  ADDI, run=1, ibus_ack on 1st req cycle -> states 1,2,3,5; rf_we=1 and pc_src=00 in WB; instret=1.
//  LW, dbus_ack after 3 wait cycles -> dbus_req high 4 cycles, dbus_we=0; rf_we=1 at WB; total 8 cycles.
//  SW then BEQ taken then JALR -> rf_we 0,0,1; pc_src 00,01,10; dbus_we=1 only for SW.
//  ibus_ack never asserted, BUS_TIMEOUT=16 -> HALT after 16 FETCH cycles; bus_err=1; halted=1; ibus_req=0.
//  IR=32'h0 (dec_illegal=1) -> HALT from DECODE; bus_err=0; no pc_w; instret unchanged.
//  reset=1 during MEM wait -> next cycle state=IDLE, dbus_req=0, instret=0; run=0 keeps IDLE.

Source files
------------

// File: rtl/rv32i_multicycle_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_multicycle_control_pkg: state codes and PC source codes.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rv32i_multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_IMM  = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  // JALR wins over JAL/taken branch; both of those use pc+imm.
  function automatic logic [1:0] pc_src_sel(input logic jal, input logic jalr,
                                            input logic branch, input logic taken);
    if (jalr)                     return PC_SRC_JALR;
    else if (jal || (branch && taken)) return PC_SRC_IMM;
    else                          return PC_SRC_PC4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_multicycle_control_bus_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_multicycle_control_bus_wait_timer: bus wait cycle counter.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rv32i_multicycle_control_bus_wait_timer #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)         count_d = '0;
    else if (count_en_i) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expired_o = (count_q == CW'(BUS_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/rv32i_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rv32i_multicycle_control
  import rv32i_multicycle_control_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  output logic             ibus_req_o,
  input  logic             ibus_ack_i,
  output logic             ir_w_o,
  input  logic             dec_illegal_i,
  input  logic             dec_alu_sel_i,
  input  logic             dec_reg_w_i,
  input  logic             dec_data_r_i,
  input  logic             dec_data_w_i,
  input  logic             dec_branch_i,
  input  logic             dec_jal_i,
  input  logic             dec_jalr_i,
  input  logic             branch_taken_i,
  output logic             alu_en_o,
  output logic             dbus_req_o,
  output logic             dbus_we_o,
  input  logic             dbus_ack_i,
  output logic             rf_we_o,
  output logic             pc_w_o,
  output logic [1:0]       pc_src_o,
  output logic             halted_o,
  output logic             bus_err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t           state_q, state_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             w_timer_clear, w_timer_count_en, w_timer_expired;

  // Timer sits at zero outside the two wait states, so every entry starts fresh.
  assign w_timer_clear = !((state_q == S_FETCH) || (state_q == S_MEM));

  rv32i_multicycle_control_bus_wait_timer #(
    .BUS_TIMEOUT (BUS_TIMEOUT)
  ) u_wait_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (w_timer_clear),
    .count_en_i (w_timer_count_en),
    .expired_o  (w_timer_expired)
  );

  always_comb begin
    state_d          = state_q;
    bus_err_d        = bus_err_q;
    instret_d        = instret_q;
    w_timer_count_en = 1'b0;
    ibus_req_o       = 1'b0;
    ir_w_o           = 1'b0;
    alu_en_o         = 1'b0;
    dbus_req_o       = 1'b0;
    dbus_we_o        = 1'b0;
    rf_we_o          = 1'b0;
    pc_w_o           = 1'b0;
    pc_src_o         = PC_SRC_PC4;
    case (state_q)
      S_IDLE: if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        ibus_req_o = 1'b1;
        if (ibus_ack_i) begin
          ir_w_o  = 1'b1;
          state_d = S_DECODE;
        end else if (w_timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          w_timer_count_en = 1'b1;
        end
      end
      S_DECODE: state_d = dec_illegal_i ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_en_o = dec_alu_sel_i;
        state_d  = (dec_data_r_i || dec_data_w_i) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dbus_req_o = 1'b1;
        dbus_we_o  = dec_data_w_i;
        if (dbus_ack_i) begin
          state_d = S_WB;
        end else if (w_timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          w_timer_count_en = 1'b1;
        end
      end
      S_WB: begin
        pc_w_o    = 1'b1;
        rf_we_o   = dec_reg_w_i && !dec_data_w_i && !dec_branch_i;
        pc_src_o  = pc_src_sel(dec_jal_i, dec_jalr_i, dec_branch_i, branch_taken_i);
        instret_d = instret_q + CNT_W'(1);
        state_d   = run_i ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign halted_o  = (state_q == S_HALT);
  assign bus_err_o = bus_err_q;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32i_multicycle_control: directed self-checking bench for the         |
// | multi-cycle sequencer. Rev 1.0                                           |
// +--------------------------------------------------------------------------+
module tb_rv32i_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, run, ibus_ack, dbus_ack;
  logic       dec_illegal, dec_alu_sel, dec_reg_w, dec_data_r, dec_data_w;
  logic       dec_branch, dec_jal, dec_jalr, branch_taken;
  logic       ibus_req, ir_w, alu_en, dbus_req, dbus_we, rf_we, pc_w, halted, bus_err;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [3:0] instret;

  int n_chk = 0;
  int n_err = 0;

  int          n_cyc, n_dreq, n_dwe, n_pcw, n_irw;
  logic        wb_rf_we;
  logic [1:0]  wb_pc_src;
  logic [31:0] seq;

  always #5 clk = ~clk;

  rv32i_multicycle_control #(.BUS_TIMEOUT(16), .CNT_W(4)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .ibus_req_o(ibus_req), .ibus_ack_i(ibus_ack), .ir_w_o(ir_w),
    .dec_illegal_i(dec_illegal), .dec_alu_sel_i(dec_alu_sel), .dec_reg_w_i(dec_reg_w),
    .dec_data_r_i(dec_data_r), .dec_data_w_i(dec_data_w), .dec_branch_i(dec_branch),
    .dec_jal_i(dec_jal), .dec_jalr_i(dec_jalr), .branch_taken_i(branch_taken),
    .alu_en_o(alu_en), .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_ack_i(dbus_ack),
    .rf_we_o(rf_we), .pc_w_o(pc_w), .pc_src_o(pc_src), .halted_o(halted),
    .bus_err_o(bus_err), .state_o(state), .instret_o(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags = {illegal, alu_sel, reg_w, data_r, data_w, branch, jal, jalr, taken}
  task automatic setf(input logic [8:0] f);
    {dec_illegal, dec_alu_sel, dec_reg_w, dec_data_r, dec_data_w,
     dec_branch, dec_jal, dec_jalr, branch_taken} = f;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Runs one instruction from IDLE; acks arrive after iwait/dwait wait cycles.
  // Stops on return to IDLE, on HALT, or after limit cycles.
  task automatic exec_instr(input int iwait, input int dwait, input int limit);
    int fw = 0;
    int dw = 0;
    n_cyc = 0; n_dreq = 0; n_dwe = 0; n_pcw = 0; n_irw = 0;
    wb_rf_we = 1'b0; wb_pc_src = 2'b11; seq = 32'h0;
    run = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      ibus_ack = (state == 3'd1) && (fw == iwait);
      dbus_ack = (state == 3'd4) && (dw == dwait);
      if (state == 3'd1) fw++;
      if (state == 3'd4) dw++;
      #1;
      if (state == 3'd0 || state == 3'd7) break;
      run = 1'b0;
      n_cyc++;
      seq = {seq[27:0], 1'b0, state};
      if (dbus_req) n_dreq++;
      if (dbus_req && dbus_we) n_dwe++;
      if (pc_w) n_pcw++;
      if (ir_w) n_irw++;
      if (state == 3'd5) begin
        wb_rf_we  = rf_we;
        wb_pc_src = pc_src;
      end
    end
    ibus_ack = 1'b0;
    dbus_ack = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; ibus_ack = 1'b0; dbus_ack = 1'b0;
    setf(9'b0);
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_hold", 32'(state), 32'd0);

    // ADDI: alu_sel + reg_w
    setf(9'b0_1_1_0_0_0_0_0_0);
    exec_instr(0, 0, 40);
    chk("addi_seq", seq, 32'h1235);
    chk("addi_irw", 32'(n_irw), 32'd1);
    chk("addi_rf_we", 32'(wb_rf_we), 32'd1);
    chk("addi_pc_src", 32'(wb_pc_src), 32'd0);
    chk("addi_pcw", 32'(n_pcw), 32'd1);
    chk("addi_instret", 32'(instret), 32'd1);

    // LW with 3 data wait cycles
    setf(9'b0_1_1_1_0_0_0_0_0);
    exec_instr(0, 3, 40);
    chk("lw_cycles", 32'(n_cyc), 32'd8);
    chk("lw_seq", seq, 32'h12344445);
    chk("lw_dreq", 32'(n_dreq), 32'd4);
    chk("lw_dwe", 32'(n_dwe), 32'd0);
    chk("lw_rf_we", 32'(wb_rf_we), 32'd1);

    // SW (reg_w set to exercise the store mask)
    setf(9'b0_1_1_0_1_0_0_0_0);
    exec_instr(0, 0, 40);
    chk("sw_seq", seq, 32'h12345);
    chk("sw_dwe", 32'(n_dwe), 32'd1);
    chk("sw_rf_we", 32'(wb_rf_we), 32'd0);
    chk("sw_pc_src", 32'(wb_pc_src), 32'd0);

    // BEQ taken (reg_w set to exercise the branch mask)
    setf(9'b0_0_1_0_0_1_0_0_1);
    exec_instr(0, 0, 40);
    chk("beq_rf_we", 32'(wb_rf_we), 32'd0);
    chk("beq_pc_src", 32'(wb_pc_src), 32'd1);
    chk("beq_dwe", 32'(n_dwe), 32'd0);

    // JALR
    setf(9'b0_1_1_0_0_0_0_1_0);
    exec_instr(0, 0, 40);
    chk("jalr_rf_we", 32'(wb_rf_we), 32'd1);
    chk("jalr_pc_src", 32'(wb_pc_src), 32'd2);
    chk("jalr_dwe", 32'(n_dwe), 32'd0);

    // BNE not taken
    setf(9'b0_0_0_0_0_1_0_0_0);
    exec_instr(0, 0, 40);
    chk("bnt_pc_src", 32'(wb_pc_src), 32'd0);
    chk("bnt_instret", 32'(instret), 32'd6);

    // JAL
    setf(9'b0_0_1_0_0_0_1_0_0);
    exec_instr(0, 0, 40);
    chk("jal_pc_src", 32'(wb_pc_src), 32'd1);
    chk("jal_rf_we", 32'(wb_rf_we), 32'd1);

    // Ack on the limit cycle wins: fetch then data
    setf(9'b0_1_1_0_0_0_0_0_0);
    exec_instr(15, 0, 60);
    chk("ilim_cycles", 32'(n_cyc), 32'd19);
    chk("ilim_state", 32'(state), 32'd0);
    chk("ilim_bus_err", 32'(bus_err), 32'd0);
    setf(9'b0_1_1_1_0_0_0_0_0);
    exec_instr(0, 15, 60);
    chk("dlim_dreq", 32'(n_dreq), 32'd16);
    chk("dlim_state", 32'(state), 32'd0);
    chk("dlim_bus_err", 32'(bus_err), 32'd0);
    chk("dlim_instret", 32'(instret), 32'd9);

    // Illegal instruction halts from DECODE
    setf(9'b1_0_0_0_0_0_0_0_0);
    exec_instr(0, 0, 40);
    chk("ill_seq", seq, 32'h12);
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_bus_err", 32'(bus_err), 32'd0);
    chk("ill_pcw", 32'(n_pcw), 32'd0);
    chk("ill_instret", 32'(instret), 32'd9);
    run = 1'b1;
    step(); step();
    chk("halt_ignores_run", 32'(state), 32'd7);
    chk("halt_no_req", 32'(ibus_req), 32'd0);
    run = 1'b0;

    // Reset out of HALT, then reset during MEM wait
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    setf(9'b0_1_1_1_0_0_0_0_0);
    exec_instr(0, 100, 5);
    chk("midmem_state", 32'(state), 32'd4);
    chk("midmem_dreq", 32'(dbus_req), 32'd1);
    reset = 1'b1;
    step();
    chk("rstmem_state", 32'(state), 32'd0);
    chk("rstmem_dreq", 32'(dbus_req), 32'd0);
    chk("rstmem_rf_we", 32'(rf_we), 32'd0);
    chk("rstmem_pcw", 32'(pc_w), 32'd0);
    chk("rstmem_instret", 32'(instret), 32'd0);
    reset = 1'b0; run = 1'b0;
    step();
    chk("rstmem_idle", 32'(state), 32'd0);

    // Fetch timeout: ibus_ack never arrives
    setf(9'b0_1_1_0_0_0_0_0_0);
    exec_instr(1000, 0, 40);
    chk("to_fetch_cycles", 32'(n_cyc), 32'd16);
    chk("to_state", 32'(state), 32'd7);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_ibus_req", 32'(ibus_req), 32'd0);
    chk("to_irw", 32'(n_irw), 32'd0);

    // Data timeout
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst3_bus_err", 32'(bus_err), 32'd0);
    setf(9'b0_1_1_0_1_0_0_0_0);
    exec_instr(0, 1000, 40);
    chk("dto_dreq", 32'(n_dreq), 32'd16);
    chk("dto_bus_err", 32'(bus_err), 32'd1);
    chk("dto_dbus_req", 32'(dbus_req), 32'd0);
    chk("dto_instret", 32'(instret), 32'd0);

    // instret wraps at 2^CNT_W
    reset = 1'b1; step(); reset = 1'b0;
    setf(9'b0_1_1_0_0_0_0_0_0);
    for (int i = 0; i < 15; i++) exec_instr(0, 0, 40);
    chk("wrap_pre", 32'(instret), 32'd15);
    exec_instr(0, 0, 40);
    chk("wrap_post", 32'(instret), 32'd0);
    chk("wrap_halted", 32'(halted), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
